// File: rtl/intra_nb_fetch.sv
// intra_nb_fetch: neighbour-sample fetch and write-back for the 16x16
// intra-mode selector.
//
// For a macroblock (x,y) it returns the top row, left column and top-left
// corner reconstructed samples. Frame edges are substituted with 127 above
// and 129 to the left. After the selector finishes, the winning
// reconstruction is written back:
//   - its bottom row goes into a per-column line buffer;
//   - its right column becomes the left neighbour of the next macroblock.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting; wb_start has priority over start
// RD    | line buffer read issued at x_lat
// RDW   | read data captured into top_reg; output registers loaded
// OUT   | top/left/top_left valid, nb_valid pulses
// WB    | bottom row written to line buffer; left/corner updated
// WBD   | wb_done pulses
module intra_nb_fetch #(
    parameter int BLOCK_SIZE = 16,
    parameter int MAX_MB_W   = 64,
    parameter int AW         = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [9:0]                          x,
    input  logic [9:0]                          y,
    output logic [8*BLOCK_SIZE-1:0]             top,
    output logic [8*BLOCK_SIZE-1:0]             left,
    output logic [7:0]                          top_left,
    output logic                                nb_valid,
    input  logic                                wb_start,
    input  logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0]  rec,
    output logic                                wb_done,
    output logic                                busy
);

    localparam int ROW_W = 8 * BLOCK_SIZE;
    localparam int MB_W  = ROW_W * BLOCK_SIZE;

    localparam logic [7:0] TOP_EDGE  = 8'h7F;
    localparam logic [7:0] LEFT_EDGE = 8'h81;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_RDW  = 3'd2,
        S_OUT  = 3'd3,
        S_WB   = 3'd4,
        S_WBD  = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [9:0]       x_lat;
    logic [9:0]       y_lat;
    logic [ROW_W-1:0] top_reg;
    logic [ROW_W-1:0] left_reg;
    logic [7:0]       corner_reg;

    // Line buffer: one bottom row per macroblock column, never reset.
    logic [ROW_W-1:0] line_buf [MAX_MB_W];
    logic [ROW_W-1:0] lb_rdata;
    logic [AW-1:0]    lb_addr;
    logic             lb_we;
    logic             lb_re;

    logic             accept_fetch;
    logic             load_out;

    logic [ROW_W-1:0] rec_bottom;
    logic [ROW_W-1:0] rec_right;
    logic             unused_rec;

    // Out-of-range x wraps onto the low address bits.
    assign lb_addr    = x_lat[AW-1:0];
    assign rec_bottom = rec[MB_W-1 -: ROW_W];
    assign unused_rec = ^rec;

    // Gather the rightmost pixel of every row into the next left column.
    always_comb begin
        rec_right = '0;
        for (int r = 0; r < BLOCK_SIZE; r++) begin
            rec_right[8*r +: 8] = rec[8*(BLOCK_SIZE*r + BLOCK_SIZE - 1) +: 8];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a start colliding with wb_start is dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (wb_start) begin
                    state_nxt = S_WB;
                end else if (start) begin
                    state_nxt = S_RD;
                end
            end
            S_RD:    state_nxt = S_RDW;
            S_RDW:   state_nxt = S_OUT;
            S_OUT:   state_nxt = S_IDLE;
            S_WB:    state_nxt = S_WBD;
            S_WBD:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output and strobe decode from the current state.
    always_comb begin
        nb_valid     = 1'b0;
        wb_done      = 1'b0;
        busy         = 1'b1;
        lb_we        = 1'b0;
        lb_re        = 1'b0;
        load_out     = 1'b0;
        accept_fetch = 1'b0;
        case (state)
            S_IDLE: begin
                busy         = 1'b0;
                accept_fetch = start & ~wb_start;
            end
            S_RD:    lb_re    = 1'b1;
            S_RDW:   load_out = 1'b1;
            S_OUT:   nb_valid = 1'b1;
            S_WB:    lb_we    = 1'b1;
            S_WBD:   wb_done  = 1'b1;
            default: busy     = 1'b0;
        endcase
    end

    // Single-port line buffer: write wins, read data registered.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            line_buf[lb_addr] <= rec_bottom;
        end else if (lb_re) begin
            lb_rdata <= line_buf[lb_addr];
        end
    end

    // Request coordinates, captured only on an accepted fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_lat <= '0;
            y_lat <= '0;
        end else if (accept_fetch) begin
            x_lat <= x;
            y_lat <= y;
        end
    end

    // Neighbour state: top from the line buffer, left/corner from write-back.
    // corner_reg takes the previous fetch's top row end, which is the correct
    // top-left only when the caller keeps raster fetch/write-back order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_reg    <= '0;
            left_reg   <= '0;
            corner_reg <= '0;
        end else begin
            if (load_out) begin
                top_reg <= lb_rdata;
            end
            if (lb_we) begin
                left_reg   <= rec_right;
                corner_reg <= top_reg[ROW_W-1 -: 8];
            end
        end
    end

    // Output registers load on entry to OUT so data lines up with nb_valid,
    // then hold until the next fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top      <= '0;
            left     <= '0;
            top_left <= '0;
        end else if (load_out) begin
            top  <= (y_lat == 10'd0) ? {BLOCK_SIZE{TOP_EDGE}}  : lb_rdata;
            left <= (x_lat == 10'd0) ? {BLOCK_SIZE{LEFT_EDGE}} : left_reg;
            if (y_lat == 10'd0) begin
                top_left <= TOP_EDGE;
            end else if (x_lat == 10'd0) begin
                top_left <= LEFT_EDGE;
            end else begin
                top_left <= corner_reg;
            end
        end
    end

endmodule

// File: tb/tb_intra_nb_fetch.sv
// Directed testbench for intra_nb_fetch.
module tb_intra_nb_fetch;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [9:0]    x = '0;
    logic [9:0]    y = '0;
    logic [127:0]  top;
    logic [127:0]  left;
    logic [7:0]    top_left;
    logic          nb_valid;
    logic          wb_start = 1'b0;
    logic [2047:0] rec = '0;
    logic          wb_done;
    logic          busy;

    int tests  = 0;
    int failed = 0;

    intra_nb_fetch #(.BLOCK_SIZE(16), .MAX_MB_W(64), .AW(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x        (x),
        .y        (y),
        .top      (top),
        .left     (left),
        .top_left (top_left),
        .nb_valid (nb_valid),
        .wb_start (wb_start),
        .rec      (rec),
        .wb_done  (wb_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // pixel(r,c) = 16r + c + 4*mbx, truncated to 8 bits
    function automatic logic [2047:0] make_rec(input int mbx);
        logic [2047:0] v;
        v = '0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                v[8*(16*r+c) +: 8] = 8'(16*r + c + 4*mbx);
            end
        end
        return v;
    endfunction

    // byte i = base + step*i
    function automatic logic [127:0] ramp(input int base, input int step);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            v[8*i +: 8] = 8'(base + step*i);
        end
        return v;
    endfunction

    // Issue a fetch, capture outputs during nb_valid, return one cycle later.
    task automatic do_fetch(input int fx, input int fy, output int cyc,
                            output logic [127:0] t_o, output logic [127:0] l_o,
                            output logic [7:0] tl_o);
        x = 10'(fx);
        y = 10'(fy);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (nb_valid !== 1'b1 && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (nb_valid !== 1'b1) cyc = -1;
        t_o  = top;
        l_o  = left;
        tl_o = top_left;
        @(posedge clk); #1;
    endtask

    task automatic do_wb(input logic [2047:0] rv, output int cyc);
        rec = rv;
        wb_start = 1'b1;
        @(posedge clk); #1;
        wb_start = 1'b0;
        cyc = 0;
        while (wb_done !== 1'b1 && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (wb_done !== 1'b1) cyc = -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        tests++;
        if ({top, left, top_left, nb_valid, wb_done, busy} !== '0) begin
            failed++;
            $display("FAIL reset_outputs: got top=%h left=%h tl=%h v=%b d=%b b=%b, want all 0",
                     top, left, top_left, nb_valid, wb_done, busy);
        end
    endtask

    task automatic test_first_fetch();
        int bcnt;
        int vcyc;
        int wcyc;
        logic [127:0] t_c;
        logic [127:0] l_c;
        logic [7:0]   tl_c;
        bcnt = 0;
        vcyc = -1;
        t_c = '0; l_c = '0; tl_c = '0;
        x = 10'd0; y = 10'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1) bcnt++;
            if (nb_valid === 1'b1 && vcyc < 0) begin
                vcyc = i;
                t_c = top; l_c = left; tl_c = top_left;
            end
            @(posedge clk); #1;
        end
        tests++;
        if (vcyc !== 2) begin
            failed++;
            $display("FAIL first_latency: got %0d, want 2 edges after start", vcyc);
        end
        tests++;
        if (bcnt !== 3) begin
            failed++;
            $display("FAIL first_busy_cycles: got %0d, want 3", bcnt);
        end
        tests++;
        if (t_c !== {16{8'h7F}} || l_c !== {16{8'h81}} || tl_c !== 8'h7F) begin
            failed++;
            $display("FAIL first_edges: got top=%h left=%h tl=%h, want 7F.. 81.. 7F",
                     t_c, l_c, tl_c);
        end
        do_wb(make_rec(0), wcyc);
        tests++;
        if (wcyc !== 1) begin
            failed++;
            $display("FAIL wb_latency_mb0: got %0d, want 1", wcyc);
        end
    endtask

    task automatic test_row0();
        int fcyc;
        int wcyc;
        logic [127:0] t_o;
        logic [127:0] l_o;
        logic [7:0]   tl_o;
        for (int mx = 1; mx < 4; mx++) begin
            do_fetch(mx, 0, fcyc, t_o, l_o, tl_o);
            tests++;
            if (fcyc !== 2 || t_o !== {16{8'h7F}} || tl_o !== 8'h7F
                || l_o !== ramp(15 + 4*(mx-1), 16)) begin
                failed++;
                $display("FAIL row0_mb%0d: got lat=%0d top=%h left=%h tl=%h, want lat=2 left=%h",
                         mx, fcyc, t_o, l_o, tl_o, ramp(15 + 4*(mx-1), 16));
            end
            do_wb(make_rec(mx), wcyc);
            tests++;
            if (wcyc !== 1) begin
                failed++;
                $display("FAIL row0_wb%0d: got latency %0d, want 1", mx, wcyc);
            end
        end
    endtask

    task automatic test_row1();
        int fcyc;
        int wcyc;
        logic [127:0] t_o;
        logic [127:0] l_o;
        logic [7:0]   tl_o;
        do_fetch(0, 1, fcyc, t_o, l_o, tl_o);
        tests++;
        if (t_o !== ramp(240, 1) || l_o !== {16{8'h81}} || tl_o !== 8'h81) begin
            failed++;
            $display("FAIL row1_mb0: got top=%h left=%h tl=%h, want top=%h left=81.. tl=81",
                     t_o, l_o, tl_o, ramp(240, 1));
        end
        do_wb(make_rec(0), wcyc);
        do_fetch(1, 1, fcyc, t_o, l_o, tl_o);
        tests++;
        if (t_o !== ramp(244, 1) || l_o !== ramp(15, 16) || tl_o !== 8'd255) begin
            failed++;
            $display("FAIL row1_mb1: got top=%h left=%h tl=%h, want top=%h left=%h tl=ff",
                     t_o, l_o, tl_o, ramp(244, 1), ramp(15, 16));
        end
        do_wb(make_rec(1), wcyc);
    endtask

    task automatic test_collision_and_busy_start();
        int vcnt;
        int dcyc;
        int fcyc;
        logic [127:0] t_c;
        logic [7:0]   tl_c;
        vcnt = 0;
        dcyc = -1;
        rec = make_rec(1);
        x = 10'd5; y = 10'd1;
        start = 1'b1; wb_start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; wb_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (nb_valid === 1'b1) vcnt++;
            if (wb_done === 1'b1 && dcyc < 0) dcyc = i;
            @(posedge clk); #1;
        end
        tests++;
        if (vcnt !== 0 || dcyc !== 1) begin
            failed++;
            $display("FAIL collision: got nb_valid pulses=%0d wb_done at %0d, want 0 and 1",
                     vcnt, dcyc);
        end

        // Fetch (2,1), then request another fetch while in OUT.
        x = 10'd2; y = 10'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fcyc = 0;
        while (nb_valid !== 1'b1 && fcyc < 8) begin
            @(posedge clk); #1;
            fcyc++;
        end
        t_c = top;
        tl_c = top_left;
        tests++;
        if (fcyc !== 2 || t_c !== ramp(248, 1) || tl_c !== 8'h03) begin
            failed++;
            $display("FAIL row1_mb2: got lat=%0d top=%h tl=%h, want lat=2 top=%h tl=03",
                     fcyc, t_c, tl_c, ramp(248, 1));
        end
        x = 10'd3; y = 10'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (nb_valid === 1'b1 || busy === 1'b1) vcnt++;
            @(posedge clk); #1;
        end
        tests++;
        if (vcnt !== 0 || top !== ramp(248, 1)) begin
            failed++;
            $display("FAIL start_in_out: got active cycles=%0d top=%h, want 0 and %h",
                     vcnt, top, ramp(248, 1));
        end
        do_wb(make_rec(2), fcyc);
    endtask

    task automatic test_reset_mid();
        int vcnt;
        int fcyc;
        logic [127:0] t_o;
        logic [127:0] l_o;
        logic [7:0]   tl_o;
        x = 10'd3; y = 10'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests++;
        if ({top, left, top_left, nb_valid, wb_done, busy} !== '0) begin
            failed++;
            $display("FAIL reset_mid_outputs: got top=%h left=%h tl=%h v=%b b=%b, want all 0",
                     top, left, top_left, nb_valid, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (nb_valid === 1'b1) vcnt++;
            @(posedge clk); #1;
        end
        tests++;
        if (vcnt !== 0) begin
            failed++;
            $display("FAIL reset_mid_pulse: got %0d nb_valid pulses, want 0", vcnt);
        end
        do_fetch(2, 1, fcyc, t_o, l_o, tl_o);
        tests++;
        if (fcyc !== 2 || t_o !== ramp(248, 1) || l_o !== '0 || tl_o !== 8'h00) begin
            failed++;
            $display("FAIL after_reset_fetch: got lat=%0d top=%h left=%h tl=%h, want lat=2 top=%h left=0 tl=0",
                     fcyc, t_o, l_o, tl_o, ramp(248, 1));
        end
        do_wb(make_rec(2), fcyc);
    endtask

    task automatic test_addr_boundary();
        int fcyc;
        int wcyc;
        logic [127:0] t_o;
        logic [127:0] l_o;
        logic [7:0]   tl_o;
        do_fetch(63, 0, fcyc, t_o, l_o, tl_o);
        do_wb(make_rec(63), wcyc);
        do_fetch(63, 1, fcyc, t_o, l_o, tl_o);
        tests++;
        if (fcyc !== 2 || t_o !== ramp(236, 1)) begin
            failed++;
            $display("FAIL addr_63: got lat=%0d top=%h, want lat=2 top=%h",
                     fcyc, t_o, ramp(236, 1));
        end
        do_wb(make_rec(63), wcyc);
        do_fetch(0, 1, fcyc, t_o, l_o, tl_o);
        tests++;
        if (t_o !== ramp(240, 1)) begin
            failed++;
            $display("FAIL addr_0_intact: got top=%h, want %h", t_o, ramp(240, 1));
        end
        do_wb(make_rec(0), wcyc);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_first_fetch();
        test_row0();
        test_row1();
        test_collision_and_busy_start();
        test_reset_mid();
        test_addr_boundary();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
